uart_receiver: RTL

Serial-to-parallel UART receiver, 8N1, LSB first. It is the receive half of the full-duplex UART and pairs with the existing transmitter. It runs on the 50 MHz system clock and uses a 16× oversampling clock-enable from the baud generator. It delivers each received byte with a ready flag, a clear handshake, framing-error status and overrun status.

---
 rtl/uart_receiver_if.sv | 21 ++
 rtl/uart_receiver.sv | 114 +++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// Receive-side bus of the UART: serial line, oversample strobe, consumer handshake and status.
interface uart_receiver_if;
  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport master (
    output rx, clken, rdy_clr,
    input  dout, rdy, frame_err, overrun, rx_busy
  );

  modport slave (
    input  rx, clken, rdy_clr,
    output dout, rdy, frame_err, overrun, rx_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, driven by an OVERSAMPLE-times bit-rate clock enable.
// Delivers each good byte with rdy/rdy_clr handshake plus framing-error and overrun status.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic            clk_50m,
  input  logic            rst_n,
  uart_receiver_if.slave  bus
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitpos;
  logic [7:0]    r_shift;
  logic [7:0]    r_dout;
  logic          r_rdy;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_rx_busy;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_cnt       <= '0;
      r_bitpos    <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_rx_busy   <= 1'b0;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;

      // Clear first so a coincident good-stop update below takes priority.
      if (bus.rdy_clr) begin
        r_rdy     <= 1'b0;
        r_overrun <= 1'b0;
      end

      if (bus.clken) begin
        case (r_state)
          IDLE: begin
            if (!r_rx_s) begin
              r_state   <= START;
              r_cnt     <= '0;
              r_rx_busy <= 1'b1;
            end
          end
          START: begin
            if (r_cnt == CNT_MID) begin
              r_cnt <= '0;
              if (!r_rx_s) begin
                r_state  <= DATA;
                r_bitpos <= '0;
              end else begin
                r_state   <= IDLE;
                r_rx_busy <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          DATA: begin
            if (r_cnt == CNT_LAST) begin
              r_cnt             <= '0;
              r_shift[r_bitpos] <= r_rx_s;
              if (r_bitpos == 3'd7) r_state  <= STOP;
              else                  r_bitpos <= r_bitpos + 3'd1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          STOP: begin
            if (r_cnt == CNT_LAST) begin
              r_cnt     <= '0;
              r_state   <= IDLE;
              r_rx_busy <= 1'b0;
              if (r_rx_s) begin
                r_dout      <= r_shift;
                r_rdy       <= 1'b1;
                r_frame_err <= 1'b0;
                if (r_rdy && !bus.rdy_clr) r_overrun <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.rdy       = r_rdy;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.rx_busy   = r_rx_busy;

endmodule
